alu_issue_stage: RTL and testbench

- ID→EX issue stage: decodes one MIPS instruction per transfer into the ALU control word (ALUFun, sign) and operands (in1, in2).
- Holds results in a 2-entry skid buffer feeding the EX stage; it is the producer side of the ALU operand/function interface.
- Upstream and downstream use valid/ready handshakes. id_ready is registered, so no combinational path runs from ex_ready to id_ready.

---
 rtl/alu_pkg.sv | 82 ++++++++
 rtl/alu_issue_skid.sv | 75 +++++++
 rtl/alu_issue_stage.sv | 155 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALUFun codes, MIPS opcode and
// funct values, the packed issue word carried through the skid buffer, and
// immediate-extension helpers.
package alu_pkg;

  // ALUFun codes
  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_GEZ   = 6'b111001;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // REGIMM rt selector for bgez
  localparam logic [4:0] RT_BGEZ   = 5'd1;

  // R-type funct codes
  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2a;
  localparam logic [5:0] FN_SLTU   = 6'h2b;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [5:0]  alufun;
    logic        sign;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        illegal;
  } issue_word_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready skid buffer over an opaque word, with flush.
// in_ready is registered: it reflects "at most one entry occupied" after the
// current edge's push/pop, so there is no combinational out_ready->in_ready path.
// While empty, out_data presents RESET_WORD.
// Ports: clk, reset (sync, active-high), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data.
module alu_issue_skid #(
  parameter int unsigned      WIDTH      = 78,
  parameter int unsigned      DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [WIDTH-1:0] mem0;   // head
  logic [WIDTH-1:0] mem1;
  logic [1:0]       count;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push      = in_valid & ready_q;
  assign pop       = (count != 2'd0) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem0 : RESET_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      ready_q <= 1'b1;
      mem0    <= RESET_WORD;
      mem1    <= RESET_WORD;
    end else if (flush) begin
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= in_data;
          else               mem1 <= in_data;
          count   <= count + 2'd1;
          ready_q <= ((count + 2'd1) != FULL);
        end
        2'b01: begin
          mem0    <= mem1;
          count   <= count - 2'd1;
          ready_q <= 1'b1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count == FULL) begin
            mem0 <= mem1;
            mem1 <= in_data;
          end else begin
            mem0 <= in_data;
          end
          ready_q <= (count != FULL);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes one MIPS instruction per accepted transfer into
// ALU operands and control (in1, in2, ALUFun, sign) plus writeback info, and
// queues the result in a 2-entry skid buffer feeding EX.
// Ports: clk, reset (sync, active-high); upstream id_valid/id_ready with
//        id_instr, id_rs_data, id_rt_data; flush; downstream ex_valid/ex_ready
//        with ex_in1, ex_in2, ex_alufun, ex_sign, ex_wr_reg, ex_reg_write,
//        ex_illegal.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter logic [5:0]  RESET_ALUFUN = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_in1,
  output logic [31:0] ex_in2,
  output logic [5:0]  ex_alufun,
  output logic        ex_sign,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_reg_write,
  output logic        ex_illegal
);

  localparam int unsigned W = $bits(issue_word_t);
  localparam issue_word_t RESET_WORD = '{
    in1: '0, in2: '0, alufun: RESET_ALUFUN, sign: 1'b0,
    wr_reg: '0, reg_write: 1'b0, illegal: 1'b0
  };

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  issue_word_t dec;
  issue_word_t head;
  logic        unused_rs;

  assign op    = id_instr[31:26];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign shamt = id_instr[10:6];
  assign funct = id_instr[5:0];
  assign imm   = id_instr[15:0];

  // The rs field is not needed: its value arrives already forwarded.
  assign unused_rs = &{1'b0, id_instr[25:21]};

  always_comb begin
    dec           = '0;
    dec.in1       = id_rs_data;
    dec.in2       = id_rt_data;
    dec.alufun    = ALU_ADD;
    dec.sign      = 1'b0;
    dec.wr_reg    = rt;
    dec.reg_write = 1'b0;
    dec.illegal   = 1'b0;

    case (op)
      OP_RTYPE: begin
        dec.wr_reg    = rd;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  begin dec.alufun = ALU_ADD; dec.sign = 1'b1; end
          FN_ADDU: dec.alufun = ALU_ADD;
          FN_SUB:  begin dec.alufun = ALU_SUB; dec.sign = 1'b1; end
          FN_SUBU: dec.alufun = ALU_SUB;
          FN_AND:  dec.alufun = ALU_AND;
          FN_OR:   dec.alufun = ALU_OR;
          FN_XOR:  dec.alufun = ALU_XOR;
          FN_NOR:  dec.alufun = ALU_NOR;
          FN_SLT:  begin dec.alufun = ALU_LT; dec.sign = 1'b1; end
          FN_SLTU: dec.alufun = ALU_LT;
          FN_SLL:  begin dec.alufun = ALU_SLL; dec.in1 = {27'b0, shamt}; end
          FN_SRL:  begin dec.alufun = ALU_SRL; dec.in1 = {27'b0, shamt}; end
          FN_SRA:  begin dec.alufun = ALU_SRA; dec.in1 = {27'b0, shamt}; end
          FN_SLLV: dec.alufun = ALU_SLL;
          FN_SRLV: dec.alufun = ALU_SRL;
          FN_SRAV: dec.alufun = ALU_SRA;
          FN_JR:   begin dec.alufun = ALU_PASSA; dec.reg_write = 1'b0; end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin dec.in2 = sext16(imm); dec.sign = 1'b1; dec.reg_write = 1'b1; end
      OP_ADDIU: begin dec.in2 = sext16(imm); dec.reg_write = 1'b1; end
      OP_SLTI:  begin
        dec.in2 = sext16(imm); dec.alufun = ALU_LT; dec.sign = 1'b1; dec.reg_write = 1'b1;
      end
      OP_SLTIU: begin dec.in2 = sext16(imm); dec.alufun = ALU_LT; dec.reg_write = 1'b1; end
      OP_ANDI:  begin dec.in2 = zext16(imm); dec.alufun = ALU_AND; dec.reg_write = 1'b1; end
      OP_ORI:   begin dec.in2 = zext16(imm); dec.alufun = ALU_OR;  dec.reg_write = 1'b1; end
      OP_XORI:  begin dec.in2 = zext16(imm); dec.alufun = ALU_XOR; dec.reg_write = 1'b1; end
      OP_LUI:   begin
        dec.in1 = {imm, 16'b0}; dec.in2 = zext16(imm); dec.alufun = ALU_PASSA; dec.reg_write = 1'b1;
      end
      OP_LW:    begin dec.in2 = sext16(imm); dec.sign = 1'b1; dec.reg_write = 1'b1; end
      OP_SW:    begin dec.in2 = sext16(imm); dec.sign = 1'b1; end
      OP_BEQ:   begin dec.alufun = ALU_EQ;  dec.sign = 1'b1; end
      OP_BNE:   begin dec.alufun = ALU_NEQ; dec.sign = 1'b1; end
      OP_BLEZ:  begin dec.alufun = ALU_LEZ; dec.sign = 1'b1; dec.in2 = '0; end
      OP_BGTZ:  begin dec.alufun = ALU_GTZ; dec.sign = 1'b1; dec.in2 = '0; end
      OP_REGIMM: begin
        if (rt == RT_BGEZ) begin
          dec.alufun = ALU_GEZ; dec.sign = 1'b1; dec.in2 = '0;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.alufun    = ALU_ADD;
      dec.sign      = 1'b0;
      dec.wr_reg    = '0;
      dec.reg_write = 1'b0;
    end
    if (dec.wr_reg == 5'd0) dec.reg_write = 1'b0;
  end

  alu_issue_skid #(
    .WIDTH      (W),
    .DEPTH      (DEPTH),
    .RESET_WORD (RESET_WORD)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (id_valid),
    .in_ready  (id_ready),
    .in_data   (dec),
    .out_valid (ex_valid),
    .out_ready (ex_ready),
    .out_data  (head)
  );

  assign ex_in1       = head.in1;
  assign ex_in2       = head.in2;
  assign ex_alufun    = head.alufun;
  assign ex_sign      = head.sign;
  assign ex_wr_reg    = head.wr_reg;
  assign ex_reg_write = head.reg_write;
  assign ex_illegal   = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [5:0]  ex_alufun;
  logic        ex_sign;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(
    .DEPTH        (2),
    .RESET_ALUFUN (6'b000000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_in1       (ex_in1),
    .ex_in2       (ex_in2),
    .ex_alufun    (ex_alufun),
    .ex_sign      (ex_sign),
    .ex_wr_reg    (ex_wr_reg),
    .ex_reg_write (ex_reg_write),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, rs, rt, in1, in2;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  wr;
    logic        rw, ill, ck1, ck2, cks;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add_vec(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] in1, input logic [31:0] in2, input logic [5:0] fun,
                         input logic sign, input logic [4:0] wr, input logic rw, input logic ill,
                         input logic ck1, input logic ck2, input logic cks);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.in1 = in1; v.in2 = in2; v.fun = fun;
    v.sign = sign; v.wr = wr; v.rw = rw; v.ill = ill; v.ck1 = ck1; v.ck2 = ck2; v.cks = cks;
    vecs.push_back(v);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(ex_valid), 32'd0);
    check({tag, ".in1"},   ex_in1, 32'd0);
    check({tag, ".in2"},   ex_in2, 32'd0);
    check({tag, ".fun"},   32'(ex_alufun), 32'd0);
    check({tag, ".sign"},  32'(ex_sign), 32'd0);
    check({tag, ".wr"},    32'(ex_wr_reg), 32'd0);
    check({tag, ".rw"},    32'(ex_reg_write), 32'd0);
    check({tag, ".ill"},   32'(ex_illegal), 32'd0);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    id_valid = 1'b1; id_instr = instr; id_rs_data = rs; id_rt_data = rt;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    check_idle("rst");
    check("rst.id_ready", 32'(id_ready), 32'd1);

    //      instr                               rs            rt            in1           in2           fun        s     wr     rw    ill   ck1   ck2   cks
    add_vec(r_ins(1, 2, 3, 0, 6'h21),           32'd5,        32'd7,        32'd5,        32'd7,        6'b000000, 1'b0, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(r_ins(0, 2, 4, 3, 6'h03),           32'h11,       32'h80000000, 32'd3,        32'h80000000, 6'b100011, 1'b0, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(i_ins(6'h0f, 0, 5, 16'h1234),       32'd9,        32'd9,        32'h12340000, 32'd0,        6'b011010, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(i_ins(6'h0c, 1, 6, 16'hffff),       32'd5,        32'd0,        32'd5,        32'h0000ffff, 6'b011000, 1'b0, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(i_ins(6'h08, 1, 7, 16'hfffc),       32'd10,       32'd0,        32'd10,       32'hfffffffc, 6'b000000, 1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h0b, 1, 8, 16'hffff),       32'd3,        32'd0,        32'd3,        32'hffffffff, 6'b110101, 1'b0, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(r_ins(1, 2, 9, 0, 6'h2a),           32'd1,        32'd2,        32'd1,        32'd2,        6'b110101, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(r_ins(1, 2, 10, 0, 6'h27),          32'ha5a5,     32'h0f0f,     32'ha5a5,     32'h0f0f,     6'b010001, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(r_ins(1, 2, 11, 0, 6'h04),          32'd4,        32'hf,        32'd4,        32'hf,        6'b100000, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(r_ins(31, 0, 0, 0, 6'h08),          32'h400,      32'd0,        32'h400,      32'd0,        6'b011010, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(i_ins(6'h04, 1, 2, 16'h0010),       32'd6,        32'd6,        32'd6,        32'd6,        6'b110011, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h05, 1, 2, 16'h0010),       32'd6,        32'd8,        32'd6,        32'd8,        6'b110001, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h06, 1, 0, 16'h0000),       32'hffffffff, 32'd12,       32'hffffffff, 32'd0,        6'b111101, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h07, 1, 0, 16'h0000),       32'd5,        32'd12,       32'd5,        32'd0,        6'b111111, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h01, 1, 1, 16'h0008),       32'd5,        32'd99,       32'd5,        32'd0,        6'b111001, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h23, 1, 12, 16'hfff8),      32'h100,      32'd0,        32'h100,      32'hfffffff8, 6'b000000, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h2b, 1, 12, 16'h0004),      32'h100,      32'd77,       32'h100,      32'd4,        6'b000000, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(r_ins(1, 2, 0, 0, 6'h21),           32'd5,        32'd7,        32'd5,        32'd7,        6'b000000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(r_ins(1, 2, 13, 0, 6'h23),          32'd10,       32'd3,        32'd10,       32'd3,        6'b000001, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(r_ins(1, 2, 15, 0, 6'h22),          32'd10,       32'd3,        32'd10,       32'd3,        6'b000001, 1'b1, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(i_ins(6'h3f, 1, 2, 16'h0000),       32'd1,        32'd2,        32'd0,        32'd0,        6'b000000, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(i_ins(6'h01, 1, 2, 16'h0000),       32'd5,        32'd6,        32'd0,        32'd0,        6'b000000, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(r_ins(1, 2, 14, 0, 6'h3f),          32'd5,        32'd6,        32'd0,        32'd0,        6'b000000, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Streaming with ex_ready=1: each vector appears on ex_* one edge after accept.
    foreach (vecs[i]) begin
      present(vecs[i].instr, vecs[i].rs, vecs[i].rt);
      step();
      check($sformatf("v%0d.valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("v%0d.id_ready", i), 32'(id_ready), 32'd1);
      if (vecs[i].ck1) check($sformatf("v%0d.in1", i), ex_in1, vecs[i].in1);
      if (vecs[i].ck2) check($sformatf("v%0d.in2", i), ex_in2, vecs[i].in2);
      check($sformatf("v%0d.fun", i), 32'(ex_alufun), 32'(vecs[i].fun));
      if (vecs[i].cks) check($sformatf("v%0d.sign", i), 32'(ex_sign), 32'(vecs[i].sign));
      check($sformatf("v%0d.rw", i), 32'(ex_reg_write), 32'(vecs[i].rw));
      if (vecs[i].rw) check($sformatf("v%0d.wr", i), 32'(ex_wr_reg), 32'(vecs[i].wr));
      check($sformatf("v%0d.ill", i), 32'(ex_illegal), 32'(vecs[i].ill));
    end
    id_valid = 1'b0;
    step();
    check_idle("drain");

    // Backpressure: three back-to-back instructions, ex_ready low.
    ex_ready = 1'b0;
    present(r_ins(1, 2, 10, 0, 6'h21), 32'd100, 32'd1);
    step();
    check("bp.ready1", 32'(id_ready), 32'd1);
    present(r_ins(1, 2, 11, 0, 6'h21), 32'd200, 32'd2);
    step();
    check("bp.ready2", 32'(id_ready), 32'd0);
    check("bp.headA", 32'(ex_wr_reg), 32'd10);
    present(r_ins(1, 2, 12, 0, 6'h21), 32'd300, 32'd3);
    step();
    check("bp.stall_ready", 32'(id_ready), 32'd0);
    check("bp.stall_headA", ex_in1, 32'd100);
    ex_ready = 1'b1;
    step();
    check("bp.headB.valid", 32'(ex_valid), 32'd1);
    check("bp.headB.wr", 32'(ex_wr_reg), 32'd11);
    check("bp.headB.in1", ex_in1, 32'd200);
    check("bp.ready3", 32'(id_ready), 32'd1);
    step();
    check("bp.headC.wr", 32'(ex_wr_reg), 32'd12);
    check("bp.headC.in1", ex_in1, 32'd300);
    id_valid = 1'b0;
    step();
    check("bp.empty", 32'(ex_valid), 32'd0);

    // Flush with both entries full and a third instruction presented.
    ex_ready = 1'b0;
    present(r_ins(1, 2, 20, 0, 6'h21), 32'd1, 32'd1);
    step();
    present(r_ins(1, 2, 21, 0, 6'h21), 32'd2, 32'd2);
    step();
    check("fl.full_ready", 32'(id_ready), 32'd0);
    check("fl.full_valid", 32'(ex_valid), 32'd1);
    present(r_ins(1, 2, 22, 0, 6'h21), 32'd3, 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    check_idle("fl.after");
    check("fl.ready", 32'(id_ready), 32'd1);
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("fl.gone%0d", k), 32'(ex_valid), 32'd0);
    end

    // Flush with a push into an empty buffer: the push is dropped.
    present(r_ins(1, 2, 23, 0, 6'h21), 32'd4, 32'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    check("fl.drop_push", 32'(ex_valid), 32'd0);

    // Reset mid-stream with two entries held.
    ex_ready = 1'b0;
    present(r_ins(1, 2, 24, 0, 6'h20), 32'd7, 32'd8);
    step();
    present(i_ins(6'h0f, 0, 25, 16'hbeef), 32'd0, 32'd0);
    step();
    check("rs.full_ready", 32'(id_ready), 32'd0);
    reset = 1'b1;
    id_valid = 1'b0;
    step();
    reset = 1'b0;
    check_idle("rs.mid");
    check("rs.ready", 32'(id_ready), 32'd1);
    ex_ready = 1'b1;
    step();
    check("rs.stay_empty", 32'(ex_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
